// File: rtl/udp_pixel_packetizer_pkg.sv
// Shared definitions for the UDP pixel packetizer.
// Holds the segment header size, default image geometry, helpers that
// derive per-instance constants from the module parameters, the read-FSM
// state enum and the byte type used by the packet RAM.
package udp_pixel_packetizer_pkg;

    localparam int HDR_BYTES         = 4;
    localparam int DEF_IM_X          = 1280;
    localparam int DEF_IM_Y          = 720;
    localparam int DEF_PAYLOAD_BYTES = 1280;

    typedef logic [7:0] byte_t;

    // Segments per frame: every frame is cut into equal payload segments.
    function automatic int segs_per_frame(input int im_x, input int im_y, input int payload_bytes);
        return (im_x * im_y * 2) / payload_bytes;
    endfunction

    // Address width of one bank.
    function automatic int addr_width(input int payload_bytes);
        return $clog2(payload_bytes);
    endfunction

    localparam int SEGS_PER_FRAME = segs_per_frame(DEF_IM_X, DEF_IM_Y, DEF_PAYLOAD_BYTES);
    localparam int ADDR_W         = addr_width(DEF_PAYLOAD_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/udp_pixel_packetizer_pkt_dpram.sv
// pkt_dpram: simple dual-port RAM holding both ping-pong payload banks.
// The bank bit is the address MSB, so the array is 2**(AW+1) bytes deep
// (bank 1 starts at 2**AW even when the payload size is not a power of two).
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - {bank, offset} write address
//   wdata  - write byte
//   raddr  - {bank, offset} read address
//   rdata  - registered read data (one cycle latency)
module pkt_dpram
    import udp_pixel_packetizer_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic        clk,
    input  logic        we,
    input  logic [AW:0] waddr,
    input  byte_t       wdata,
    input  logic [AW:0] raddr,
    output byte_t       rdata
);

    byte_t mem [0:(2**(AW+1))-1];
    byte_t rdata_d;
    byte_t rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/udp_pixel_packetizer.sv
// udp_pixel_packetizer: cuts the RGB565 byte stream into fixed-size UDP
// payload segments, prefixes each with a 4-byte {frame_num, seg_num}
// header and streams packets out through a ping-pong buffer.
// Ports:
//   gtx_clk, rst          - clock, asynchronous active-high reset
//   pixel, pixel_valid    - byte from upstream FIFO (one cycle after out_ready)
//   out_ready             - read request to the upstream FIFO
//   tx_data/valid/sop/eop - packet byte stream, tx_ready is the accept
//   tx_len                - constant UDP payload length (header + pixels)
// Handshake: a tx byte transfers on a cycle where tx_valid && tx_ready;
// while tx_valid && !tx_ready, tx_data/tx_sop/tx_eop are held unchanged.
module udp_pixel_packetizer
    import udp_pixel_packetizer_pkg::*;
#(
    parameter int IM_X          = DEF_IM_X,
    parameter int IM_Y          = DEF_IM_Y,
    parameter int PAYLOAD_BYTES = DEF_PAYLOAD_BYTES
) (
    input  logic        gtx_clk,
    input  logic        rst,
    input  logic [7:0]  pixel,
    input  logic        pixel_valid,
    output logic        out_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic        tx_ready,
    output logic [15:0] tx_len
);

    localparam int             AW        = addr_width(PAYLOAD_BYTES);
    localparam int             CW        = AW + 1;
    localparam int             SEGS      = segs_per_frame(IM_X, IM_Y, PAYLOAD_BYTES);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(PAYLOAD_BYTES - 1);
    localparam logic [CW-1:0]  PAY_LEN   = CW'(PAYLOAD_BYTES);
    localparam logic [15:0]    LAST_SEG  = 16'(SEGS - 1);

    // Write side
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]    full_q, full_d;
    logic          wr_fill;

    // Read side
    rd_state_e     state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hdr_q, hdr_d;
    logic [15:0]   frame_num_q, frame_num_d;
    logic [15:0]   seg_num_q, seg_num_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_sop_q, tx_sop_d;
    logic          tx_eop_q, tx_eop_d;
    logic          adv;
    logic          pay_done;
    byte_t         rdata;

    // ---------------- write side ----------------
    always_comb begin
        wr_fill   = pixel_valid && (wr_cnt_q == LAST_ADDR);
        // Counting the in-flight byte keeps the bank from being over-requested.
        out_ready = !rst && !full_q[wr_bank_q] &&
                    (({1'b0, wr_cnt_q} + CW'(pixel_valid)) < PAY_LEN);
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (pixel_valid) begin
            if (wr_fill) begin
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    // Clear first, then set, so a same-cycle set on the same bank wins.
    always_comb begin
        full_d = full_q;
        if (pay_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_fill) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // ---------------- read FSM: state register ----------------
    always_ff @(posedge gtx_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign adv      = !tx_valid_q || tx_ready;
    assign pay_done = (state_q == PAY) && tx_valid_q && tx_ready && tx_eop_q;

    // ---------------- read FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (full_q[rd_bank_q]) state_d = HDR;
            HDR:  if (adv && (cnt_q == CW'(HDR_BYTES - 1))) state_d = PAY;
            PAY:  if (pay_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- read FSM: outputs / datapath ----------------
    // cnt_q is the index of the next byte to load into the output register.
    always_comb begin
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        rd_bank_d   = rd_bank_q;
        frame_num_d = frame_num_q;
        seg_num_d   = seg_num_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_sop_d    = tx_sop_q;
        tx_eop_d    = tx_eop_q;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    hdr_d = {frame_num_q, seg_num_q};
                    cnt_d = '0;
                end
            end
            HDR: begin
                if (adv) begin
                    tx_valid_d = 1'b1;
                    tx_sop_d   = (cnt_q == '0);
                    tx_eop_d   = 1'b0;
                    case (cnt_q[1:0])
                        2'd0:    tx_data_d = hdr_q[31:24];
                        2'd1:    tx_data_d = hdr_q[23:16];
                        2'd2:    tx_data_d = hdr_q[15:8];
                        default: tx_data_d = hdr_q[7:0];
                    endcase
                    // Payload index restarts here so the RAM prefetches byte 0.
                    cnt_d = (cnt_q == CW'(HDR_BYTES - 1)) ? '0 : cnt_q + 1'b1;
                end
            end
            PAY: begin
                if (pay_done) begin
                    tx_valid_d = 1'b0;
                    tx_sop_d   = 1'b0;
                    tx_eop_d   = 1'b0;
                    tx_data_d  = '0;
                    rd_bank_d  = ~rd_bank_q;
                    if (seg_num_q == LAST_SEG) begin
                        seg_num_d   = '0;
                        frame_num_d = frame_num_q + 1'b1;
                    end else begin
                        seg_num_d = seg_num_q + 1'b1;
                    end
                end else if (adv) begin
                    tx_valid_d = 1'b1;
                    tx_sop_d   = 1'b0;
                    tx_eop_d   = (cnt_q == PAY_LEN - CW'(1));
                    tx_data_d  = rdata;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge gtx_clk or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            full_q      <= '0;
            rd_bank_q   <= 1'b0;
            cnt_q       <= '0;
            hdr_q       <= '0;
            frame_num_q <= '0;
            seg_num_q   <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            frame_num_q <= frame_num_d;
            seg_num_q   <= seg_num_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_sop_q    <= tx_sop_d;
            tx_eop_q    <= tx_eop_d;
        end
    end

    // Read address uses next-cycle values so rdata always equals the byte at
    // cnt_q; under a stall the same address is simply re-read.
    pkt_dpram #(.AW(AW)) u_ram (
        .clk   (gtx_clk),
        .we    (pixel_valid),
        .waddr ({wr_bank_q, wr_cnt_q}),
        .wdata (pixel),
        .raddr ({rd_bank_d, cnt_d[AW-1:0]}),
        .rdata (rdata)
    );

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_sop   = tx_sop_q;
    assign tx_eop   = tx_eop_q;
    assign tx_len   = 16'(PAYLOAD_BYTES + HDR_BYTES);

endmodule

// File: tb/tb_udp_pixel_packetizer.sv
// Bench for udp_pixel_packetizer with a small frame (16x4, 32-byte payload,
// 4 segments per frame) so frame wrap is reachable quickly.
module tb_udp_pixel_packetizer;

    localparam int IM_X = 16;
    localparam int IM_Y = 4;
    localparam int P    = 32;
    localparam int PKT  = P + 4;

    logic        gtx_clk = 1'b0;
    logic        rst;
    logic [7:0]  pixel;
    logic        pixel_valid;
    logic        out_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_ready;
    logic [15:0] tx_len;

    always #5 gtx_clk = ~gtx_clk;

    udp_pixel_packetizer #(.IM_X(IM_X), .IM_Y(IM_Y), .PAYLOAD_BYTES(P)) dut (
        .gtx_clk     (gtx_clk),
        .rst         (rst),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .out_ready   (out_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .tx_ready    (tx_ready),
        .tx_len      (tx_len)
    );

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [9:0] rx_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pv_cnt   = 0;
    int fill_cyc = 0;
    int sop_cyc  = 0;
    int gap_err = 0, stable_err = 0, idle_err = 0, ovf_err = 0;
    int rdy_mode = 0;
    int gap_mode = 0;
    int base;
    int waited;
    logic take;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_bytes(input int n, input logic [7:0] start);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = start + i[7:0];
            src_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic get_packet(input logic [15:0] frame, input logic [15:0] seg, input string tag);
        int w;
        int flag_err;
        int pay_err;
        logic [31:0] hdr;
        logic [9:0] e;
        logic [7:0] b;
        w = 0; flag_err = 0; pay_err = 0; hdr = '0;
        while (rx_q.size() < PKT && w < 3000) begin
            @(negedge gtx_clk);
            w++;
        end
        check({tag, "_arrive"}, 32'(rx_q.size() >= PKT), 32'd1);
        if (rx_q.size() < PKT) return;
        for (int i = 0; i < PKT; i++) begin
            e = rx_q.pop_front();
            if (e[9] != (i == 0)) flag_err++;
            if (e[8] != (i == PKT - 1)) flag_err++;
            if (i < 4) hdr = {hdr[23:0], e[7:0]};
            else if (exp_q.size() == 0) pay_err++;
            else begin
                b = exp_q.pop_front();
                if (b !== e[7:0]) pay_err++;
            end
        end
        check({tag, "_hdr"}, hdr, {frame, seg});
        check({tag, "_sop_eop"}, flag_err, 0);
        check({tag, "_payload"}, pay_err, 0);
    endtask

    // Upstream FIFO model: data follows a read request by one cycle.
    initial begin
        pixel_valid = 1'b0;
        pixel       = '0;
        forever begin
            @(negedge gtx_clk);
            take = out_ready && (src_q.size() > 0) && (gap_mode == 0 || $urandom_range(0, 2) != 0);
            @(posedge gtx_clk);
            #1;
            pixel_valid = take;
            if (take) pixel = src_q.pop_front();
        end
    end

    // Downstream ready driver.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge gtx_clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'b0;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: collects accepted bytes and protocol violations.
    initial begin
        logic prev_stall, prev_eop_acc, in_pkt, prev_valid, prev_sop, prev_eop;
        logic [7:0] prev_data;
        prev_stall = 0; prev_eop_acc = 0; in_pkt = 0; prev_valid = 0;
        prev_sop = 0; prev_eop = 0; prev_data = '0;
        forever begin
            @(negedge gtx_clk);
            cyc++;
            if (rst) begin
                in_pkt = 0; prev_stall = 0; prev_eop_acc = 0; prev_valid = 0;
            end else begin
                if (pixel_valid) begin
                    if (dut.full_q[dut.wr_bank_q]) ovf_err++;
                    pv_cnt++;
                    if (pv_cnt % P == 0) fill_cyc = cyc;
                end
                if (tx_valid && tx_sop && !prev_valid) sop_cyc = cyc;
                if (prev_stall && (!tx_valid || tx_data !== prev_data ||
                                   tx_sop !== prev_sop || tx_eop !== prev_eop)) stable_err++;
                if (in_pkt && !tx_valid) gap_err++;
                if (prev_eop_acc && tx_valid) idle_err++;
                prev_eop_acc = tx_valid && tx_ready && tx_eop;
                if (tx_valid && tx_ready) begin
                    rx_q.push_back({tx_sop, tx_eop, tx_data});
                    if (tx_sop) in_pkt = 1;
                    if (tx_eop) in_pkt = 0;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_sop   = tx_sop;
                prev_eop   = tx_eop;
                prev_valid = tx_valid;
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge gtx_clk);
        check("rst_out_ready", 32'(out_ready), 32'd0);
        check("rst_tx_ctrl", {29'd0, tx_valid, tx_sop, tx_eop}, 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("tx_len", 32'(tx_len), 32'd36);
        #2 rst = 1'b0;

        // Single packet, ready always high.
        push_bytes(32, 8'h00);
        get_packet(16'd0, 16'd0, "t1");
        check("t1_latency", sop_cyc - fill_cyc, 3);

        // Downstream stalled: both banks fill, then upstream is throttled.
        rdy_mode = 1;
        base = pv_cnt;
        push_bytes(96, 8'h40);
        repeat (200) @(negedge gtx_clk);
        check("t2_consumed", pv_cnt - base, 64);
        check("t2_out_ready", 32'(out_ready), 32'd0);
        check("t2_src_left", src_q.size(), 32);
        rdy_mode = 0;
        get_packet(16'd0, 16'd1, "t2a");
        get_packet(16'd0, 16'd2, "t2b");
        get_packet(16'd0, 16'd3, "t2c");

        // Random backpressure; also the first packet of frame 1.
        rdy_mode = 2;
        push_bytes(32, 8'hA0);
        get_packet(16'd1, 16'd0, "t3");
        rdy_mode = 0;

        // Upstream FIFO running dry intermittently.
        gap_mode = 1;
        push_bytes(32, 8'hC0);
        get_packet(16'd1, 16'd1, "t4");
        gap_mode = 0;

        // Reset in the middle of a payload.
        push_bytes(32, 8'hE0);
        waited = 0;
        while (rx_q.size() < 10 && waited < 3000) begin
            @(negedge gtx_clk);
            waited++;
        end
        check("t5_started", 32'(rx_q.size() >= 10), 32'd1);
        @(negedge gtx_clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", {29'd0, tx_valid, tx_sop, tx_eop}, 32'd0);
        check("t5_rst_data", 32'(tx_data), 32'd0);
        check("t5_rst_out_ready", 32'(out_ready), 32'd0);
        @(negedge gtx_clk);
        #2 rst = 1'b0;
        rx_q.delete();
        exp_q.delete();
        src_q.delete();
        push_bytes(32, 8'h33);
        get_packet(16'd0, 16'd0, "t5_post");

        // Frame counter wrap from 0xFFFF.
        repeat (3) @(negedge gtx_clk);
        force dut.frame_num_q = 16'hFFFF;
        force dut.seg_num_q   = 16'd3;
        @(negedge gtx_clk);
        release dut.frame_num_q;
        release dut.seg_num_q;
        push_bytes(64, 8'h77);
        get_packet(16'hFFFF, 16'd3, "t6a");
        get_packet(16'h0000, 16'd0, "t6b");

        repeat (5) @(negedge gtx_clk);
        check("no_valid_gaps", gap_err, 0);
        check("stall_stable", stable_err, 0);
        check("idle_after_eop", idle_err, 0);
        check("no_write_when_full", ovf_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/udp_pixel_packetizer.md
Name: udp_pixel_packetizer

Overview:
- Consumes the RGB565 byte stream from the colour-conversion stage's output FIFO (gtx_clk domain).
- Cuts the stream into fixed-size UDP payload segments and prepends a 4-byte segment header.
- Ping-pong buffers each segment so the downstream UDP/IP header/MAC stage receives gap-free packets.

Parameters:
- IM_X, 1280, image width in pixels.
- IM_Y, 720, image height in lines.
- PAYLOAD_BYTES, 1280, pixel bytes per packet. IM_X*IM_Y*2 must be an exact multiple of it; PAYLOAD_BYTES must be ≤1468.

Ports:
- gtx_clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- pixel  in  8  RGB565 byte from upstream FIFO.
- pixel_valid  in  1  pixel is valid. Arrives exactly one cycle after a cycle with out_ready=1 and the upstream FIFO non-empty.
- out_ready  out  1  read request to upstream FIFO.
- tx_data  out  8  packet byte.
- tx_valid  out  1  tx_data valid.
- tx_sop  out  1  first header byte.
- tx_eop  out  1  last payload byte.
- tx_ready  in  1  downstream accepts the byte when tx_valid&tx_ready.
- tx_len  out  16  constant PAYLOAD_BYTES+4, for the UDP length field.

Behaviour:
- Reset (asynchronous, any time, including mid-packet):
  - out_ready, tx_valid, tx_sop, tx_eop=0; tx_data=0.
  - Both banks empty; write and read bank pointers=0; wr_cnt=0; frame_num=0; seg_num=0.
  - Any partial packet is abandoned.
- Buffer: two banks of PAYLOAD_BYTES bytes each, plus one full flag per bank.
- Write side:
  - out_ready = !full[wr_bank] && (wr_cnt + pixel_valid) < PAYLOAD_BYTES, combinational. This guarantees the in-flight byte always fits, so no byte is ever dropped.
  - Each pixel_valid writes pixel at address wr_cnt and increments wr_cnt.
  - On the write of byte PAYLOAD_BYTES-1: set full[wr_bank], clear wr_cnt, toggle wr_bank.
  - pixel_valid while the bank is full cannot occur by construction; the bench asserts this.
- Read FSM:
  - IDLE: waits for full[rd_bank]. Latches hdr = {frame_num, seg_num}, then goes to HDR.
  - HDR: emits 4 bytes, big-endian: frame_num[15:8], frame_num[7:0], seg_num[15:8], seg_num[7:0]. tx_sop is asserted with byte 0. Then goes to PAY.
  - PAY: emits bank bytes at addresses 0..PAYLOAD_BYTES-1. tx_eop is asserted with the last byte. On its acceptance: clear full[rd_bank], toggle rd_bank, advance counters, return to IDLE.
- Output rules:
  - Registered outputs, AXI-stream rules: tx_data, tx_sop and tx_eop stay stable while tx_valid&!tx_ready.
  - tx_valid stays high continuously from sop to eop whenever tx_ready stays high.
  - RAM has 1-cycle read latency; the read address is prefetched so no bubble appears between the HDR→PAY transition or consecutive payload bytes.
  - Minimum one idle cycle between packets: tx_valid=0 for at least 1 cycle after eop.
- Counters:
  - seg_num counts 0..SEGS-1, where SEGS = IM_X*IM_Y*2/PAYLOAD_BYTES (default 1440). It wraps to 0 at SEGS-1.
  - On that wrap, frame_num increments, 16-bit modular (0xFFFF→0x0000).
- Simultaneous events:
  - Write side filling one bank while the read side frees the other in the same cycle: both flags update independently; no lost update.
  - The write side may fill a bank in the same cycle that bank's full flag is being cleared: the set wins. In practice this cannot occur because the banks alternate.
- Latency: first header byte appears 2 cycles after the write that sets the full flag, when tx_ready=1.

Decomposition:
- Shared package holds:
  - HDR_BYTES=4.
  - Derived SEGS_PER_FRAME.
  - ADDR_W=$clog2(PAYLOAD_BYTES).
  - Read-FSM state enum {IDLE, HDR, PAY}.
- One sub-module: pkt_dpram, a simple dual-port RAM, 8-bit wide, depth 2*PAYLOAD_BYTES, bank bit as address MSB, registered read port.

Test Plan:
- Upstream feeds 1280 bytes 0x00..0xFF repeating, tx_ready=1 → one packet of 1284 bytes. Header 00 00 00 00, payload identical, sop on byte 0, eop on byte 1283, no tx_valid gaps.
- Upstream never empty and tx_ready=0 for 5000 cycles → exactly 2560 bytes consumed, out_ready=0 afterwards, no pixel_valid lost. Release tx_ready → two packets with seg 0 then seg 1.
- tx_ready toggled randomly mid-packet → tx_data held stable while stalled; payload order preserved; byte count still 1284.
- Full frame streamed (IM_X=16, IM_Y=4, PAYLOAD_BYTES=32) → seg_num 0..3, then the next packet has frame 0x0001, seg 0. Preload frame_num=0xFFFF via force → wraps to 0x0000.
- rst asserted mid-payload for 1 cycle → outputs zero immediately. The next packet starts with header 00 00 00 00 and contains only post-reset bytes.
- Upstream FIFO empty intermittently (pixel_valid gaps) → packet still emitted only when the bank is complete, contents correct, continuous output.
